capture_controller: RTL and testbench
=====================================

Name: capture_controller

Overview:
- Central sequencing controller of the logic-analyzer capture path.
- Streams samples into sample memory while armed, and keeps writing a programmed number of post-trigger samples after the trigger.
- It then reads a programmed number of samples back out through the transmitter handshake, one word per send.
- It sits after the RLE encoder and drives the memory and output-transmitter interfaces.

Parameters:
- CNT_WIDTH, 18, width of the internal sample/read counter. It equals 16 count bits plus 2 fixed LSBs, giving counts in units of 4.

Ports:
- clock  input  1  core clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  trigger-fired indication; level, sampled every cycle.
- wrSize  input  1  one-cycle strobe that loads the size register from config_data.
- config_data  input  32  [31:16] = fwd (post-trigger count), [15:0] = bwd (readout count).
- validIn  input  1  dataIn holds a valid sample this cycle.
- dataIn  input  32  sample word.
- arm  input  1  start-capture strobe.
- busy  input  1  transmitter busy; high while the previous word is being sent.
- send  output  1  one-cycle request to transmit the current memory read word.
- memoryWrData  output  32  write data to sample memory.
- memoryRead  output  1  one-cycle memory read strobe.
- memoryWrite  output  1  memory write strobe.
- memoryLastWrite  output  1  marks the final write of the capture.

Behaviour:
- All outputs are registered and reflect the decisions of the previous cycle.
- Reset (async) sets:
  - state = IDLE;
  - fwd, bwd, counter = 0;
  - send, memoryRead, memoryWrite, memoryLastWrite = 0;
  - memoryWrData = 0.
- wrSize: fwd <= config_data[31:16] and bwd <= config_data[15:0] in any state. A change mid-capture takes effect at the next comparison.
- Strobes (send, memoryRead, memoryWrite, memoryLastWrite) default to 0 each cycle unless asserted below.
- memoryWrData <= dataIn every cycle in SAMPLE and DELAY. It holds its value otherwise.
- IDLE:
  - counter = 0;
  - arm -> SAMPLE;
  - run without arm is ignored.
- SAMPLE:
  - memoryWrite <= validIn.
  - run -> DELAY, counter <= 0. A sample valid in the same cycle as run is still written.
  - arm is ignored.
- DELAY:
  - If validIn: memoryWrite <= 1.
  - If additionally counter == {fwd,2'b11}: memoryLastWrite <= 1 (same cycle as that write), counter <= 0, state -> READ.
  - Otherwise, if validIn, counter <= counter + 1.
  - Cycles without validIn change nothing.
  - Total post-trigger writes = 4*(fwd+1), counting from the first valid cycle after entering DELAY.
- READ:
  - memoryRead <= 1 and send <= 1, each for exactly one cycle.
  - State -> READWAIT.
- READWAIT:
  - Wait while busy or send is high, so the transmitter has seen the request before busy is trusted.
  - When both are low: if counter == {bwd,2'b11}, counter <= 0 and state -> IDLE; else counter <= counter + 1 and state -> READ.
  - Total reads = 4*(bwd+1).
- Counter compare is full-width equality; the counter never wraps within one capture.
- arm and run received outside the states that consume them are ignored.
- Reset asserted mid-operation aborts immediately to IDLE with all strobes low. No last-write is issued.

Test Plan:
- Reset mid-READWAIT with busy=1 -> all outputs 0 asynchronously, state IDLE; a following arm restarts a capture.
- wrSize with config_data=0x0000_0000, arm, 3 validIn samples, run, continuous validIn:
  - exactly 4 further writes;
  - memoryLastWrite high only with the 4th;
  - then 4 send/memoryRead pulses, each with busy=0.
- wrSize with 0x0001_0002, continuous validIn after run:
  - 8 post-trigger writes, memoryLastWrite on the 8th;
  - 12 read/send pulses, then IDLE.
- Gaps in validIn during DELAY (pattern 1,0,0,1) -> counter advances only on valid cycles; write count is unchanged; memoryWrData equals dataIn of each valid cycle.
- busy held high 5 cycles after each send -> next memoryRead occurs only after busy falls; never two sends without a busy-low window.
- run asserted before arm, and arm re-asserted during DELAY -> both ignored; sequence completes with the configured counts.

Source files
------------

// File: rtl/capture_controller.sv
// capture_controller: sequences sample capture into memory, counts the
// post-trigger writes, then reads the requested number of words back out
// through the transmitter handshake. Counts run in units of 4 samples.
module capture_controller #(
   parameter int CNT_WIDTH = 18
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        run,
   input  logic        wrSize,
   input  logic [31:0] config_data,
   input  logic        validIn,
   input  logic [31:0] dataIn,
   input  logic        arm,
   input  logic        busy,
   output logic        send,
   output logic [31:0] memoryWrData,
   output logic        memoryRead,
   output logic        memoryWrite,
   output logic        memoryLastWrite
);

   typedef enum logic [2:0] {
      IDLE,
      SAMPLE,
      DELAY,
      READ,
      READWAIT
   } state_t;

   state_t                 state, state_d;
   logic [15:0]            fwd, fwd_d;
   logic [15:0]            bwd, bwd_d;
   logic [CNT_WIDTH-1:0]   counter, counter_d;
   logic [CNT_WIDTH-1:0]   fwd_limit, bwd_limit;
   logic [31:0]            wrdata_d;
   logic                   send_d, read_d, write_d, last_d;

   // Terminal counts: the programmed value with two low bits set.
   assign fwd_limit = CNT_WIDTH'({fwd, 2'b11});
   assign bwd_limit = CNT_WIDTH'({bwd, 2'b11});

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Size registers, counter and registered memory/transmitter outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fwd             <= '0;
         bwd             <= '0;
         counter         <= '0;
         send            <= 1'b0;
         memoryRead      <= 1'b0;
         memoryWrite     <= 1'b0;
         memoryLastWrite <= 1'b0;
         memoryWrData    <= '0;
      end else begin
         fwd             <= fwd_d;
         bwd             <= bwd_d;
         counter         <= counter_d;
         send            <= send_d;
         memoryRead      <= read_d;
         memoryWrite     <= write_d;
         memoryLastWrite <= last_d;
         memoryWrData    <= wrdata_d;
      end
   end

   // Next-state and next-output decisions; strobes default low every cycle.
   always_comb begin
      state_d   = state;
      fwd_d     = fwd;
      bwd_d     = bwd;
      counter_d = counter;
      wrdata_d  = memoryWrData;
      send_d    = 1'b0;
      read_d    = 1'b0;
      write_d   = 1'b0;
      last_d    = 1'b0;

      if (wrSize) begin
         fwd_d = config_data[31:16];
         bwd_d = config_data[15:0];
      end

      case (state)
         IDLE: begin
            counter_d = '0;
            if (arm) begin
               state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            wrdata_d = dataIn;
            write_d  = validIn;
            if (run) begin
               counter_d = '0;
               state_d   = DELAY;
            end
         end
         DELAY: begin
            wrdata_d = dataIn;
            if (validIn) begin
               write_d = 1'b1;
               if (counter == fwd_limit) begin
                  last_d    = 1'b1;
                  counter_d = '0;
                  state_d   = READ;
               end else begin
                  counter_d = counter + CNT_WIDTH'(1);
               end
            end
         end
         READ: begin
            read_d  = 1'b1;
            send_d  = 1'b1;
            state_d = READWAIT;
         end
         READWAIT: begin
            // send is still high in the first wait cycle, which gives the
            // transmitter one cycle to raise busy before it is trusted.
            if (!busy && !send) begin
               if (counter == bwd_limit) begin
                  counter_d = '0;
                  state_d   = IDLE;
               end else begin
                  counter_d = counter + CNT_WIDTH'(1);
                  state_d   = READ;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_capture_controller.sv
// Testbench for capture_controller: random capture sessions, expected writes
// and reads queued by the stimulus and consumed by an independent monitor.
module tb_capture_controller;

   logic        clock = 1'b0;
   logic        reset;
   logic        run;
   logic        wrSize;
   logic [31:0] config_data;
   logic        validIn;
   logic [31:0] dataIn;
   logic        arm;
   logic        busy;
   logic        send;
   logic [31:0] memoryWrData;
   logic        memoryRead;
   logic        memoryWrite;
   logic        memoryLastWrite;

   capture_controller #(.CNT_WIDTH(18)) dut (
      .clock          (clock),
      .reset          (reset),
      .run            (run),
      .wrSize         (wrSize),
      .config_data    (config_data),
      .validIn        (validIn),
      .dataIn         (dataIn),
      .arm            (arm),
      .busy           (busy),
      .send           (send),
      .memoryWrData   (memoryWrData),
      .memoryRead     (memoryRead),
      .memoryWrite    (memoryWrite),
      .memoryLastWrite(memoryLastWrite)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } wr_t;

   wr_t wq[$];
   int  total = 0;
   int  bad = 0;
   int  reads_issued = 0;
   int  reads_seen = 0;
   int  cap_id = 0;
   bit  force_long = 1'b0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void push_wr(input logic [31:0] d, input logic last);
      wr_t e;
      e.data = d;
      e.last = last;
      wq.push_back(e);
   endfunction

   // Monitor plus transmitter model: checks every output presented by the
   // DUT against the queued expectations and answers each send with busy.
   initial begin
      int  cyc = 0;
      int  busy_left = 0;
      int  len = 0;
      int  prev_len = 0;
      int  prev_send_cyc = 0;
      int  prev_cap = -1;
      wr_t e;
      busy = 1'b0;
      forever begin
         @(negedge clock);
         cyc++;
         if (reset) begin
            wq.delete();
            reads_seen = reads_issued;
            busy       = 1'b0;
            busy_left  = 0;
            prev_cap   = -1;
         end else begin
            if (memoryWrite || memoryLastWrite) begin
               check("write_expected", 64'(wq.size() != 0), 1);
               if (wq.size() != 0) begin
                  e = wq.pop_front();
                  check("wr_strobe", memoryWrite, 1);
                  check("wr_data", memoryWrData, e.data);
                  check("wr_last", memoryLastWrite, e.last);
               end
            end
            if (send || memoryRead) begin
               check("read_with_send", memoryRead, send);
            end
            if (send) begin
               check("send_expected", 64'(reads_seen < reads_issued), 1);
               reads_seen++;
               check("busy_low_at_send", busy, 0);
               if (prev_cap == cap_id) begin
                  check("send_gap", 64'(cyc - prev_send_cyc), 64'((prev_len + 2 > 3) ? prev_len + 2 : 3));
               end
               prev_send_cyc = cyc;
               prev_cap      = cap_id;
               len           = force_long ? 5 : int'($urandom_range(0, 5));
               prev_len      = len;
               busy_left     = len;
               busy          = (len > 0);
            end else if (busy_left > 0) begin
               busy_left--;
               if (busy_left == 0) begin
                  busy = 1'b0;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic capture(input int fwd, input int bwd, input int npre, input int gaps,
                          input int arm_in_delay, input int run_before, input int abort_after);
      int          total_wr;
      int          k;
      int          t;
      logic        v;
      logic [31:0] d;
      logic [31:0] last_data;
      bit          aborted;
      cap_id++;
      aborted   = 1'b0;
      last_data = '0;

      wrSize      = 1'b1;
      config_data = {16'(fwd), 16'(bwd)};
      validIn     = 1'($urandom_range(0, 1));
      dataIn      = $urandom;
      step();
      wrSize = 1'b0;

      if (run_before != 0) begin
         repeat (3) begin
            run     = 1'b1;
            validIn = 1'b1;
            dataIn  = $urandom;
            step();
         end
      end
      run = 1'b0;

      reads_issued += 4 * (bwd + 1);

      arm     = 1'b1;
      validIn = 1'($urandom_range(0, 1));
      dataIn  = $urandom;
      step();
      arm = 1'b0;

      for (int i = 0; i < npre; i++) begin
         v       = 1'($urandom_range(0, 1));
         d       = $urandom;
         validIn = v;
         dataIn  = d;
         arm     = 1'($urandom_range(0, 1));
         if (v) push_wr(d, 1'b0);
         step();
      end

      arm     = 1'b0;
      v       = 1'($urandom_range(0, 1));
      d       = $urandom;
      run     = 1'b1;
      validIn = v;
      dataIn  = d;
      if (v) push_wr(d, 1'b0);
      step();

      total_wr = 4 * (fwd + 1);
      k = 0;
      t = 0;
      while (k < total_wr) begin
         case (gaps)
            0:       v = 1'b1;
            1:       v = ((t % 4) == 0) || ((t % 4) == 3);
            default: v = 1'($urandom_range(0, 1));
         endcase
         d       = $urandom;
         validIn = v;
         dataIn  = d;
         arm     = (arm_in_delay != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         run     = 1'($urandom_range(0, 1));
         if (v) begin
            push_wr(d, k == total_wr - 1);
            k++;
            last_data = d;
         end
         t++;
         step();
      end
      arm = 1'b0;
      run = 1'b0;

      t = 0;
      while (reads_seen < reads_issued && t < 5000 && !aborted) begin
         validIn = 1'($urandom_range(0, 1));
         dataIn  = $urandom;
         run     = 1'($urandom_range(0, 1));
         if (abort_after > 0 && busy &&
             (reads_issued - reads_seen) <= 4 * (bwd + 1) - abort_after) begin
            #1 reset = 1'b1;
            #1;
            check("abort_send", send, 0);
            check("abort_read", memoryRead, 0);
            check("abort_write", memoryWrite, 0);
            check("abort_last", memoryLastWrite, 0);
            check("abort_wrdata", memoryWrData, 0);
            step();
            reset = 1'b0;
            step();
            aborted = 1'b1;
         end else begin
            step();
            t++;
         end
      end
      if (abort_after > 0) begin
         check("abort_reached", aborted, 1);
      end
      if (!aborted) begin
         check("reads_outstanding", 64'(reads_issued - reads_seen), 0);
         t = 0;
         while (busy && t < 50) begin
            step();
            t++;
         end
         repeat (3) step();
         check("wrdata_hold", memoryWrData, last_data);
         check("write_queue_drained", 64'(wq.size()), 0);
      end
   endtask

   // Stimulus: reset, directed sessions from the test plan, then random ones.
   initial begin
      reset       = 1'b0;
      run         = 1'b0;
      wrSize      = 1'b0;
      config_data = '0;
      validIn     = 1'b0;
      dataIn      = '0;
      arm         = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("rst_send", send, 0);
      check("rst_read", memoryRead, 0);
      check("rst_write", memoryWrite, 0);
      check("rst_last", memoryLastWrite, 0);
      check("rst_wrdata", memoryWrData, 0);
      step();
      step();
      reset = 1'b0;
      step();

      capture(0, 0, 3, 0, 0, 1, 0);
      capture(1, 2, 5, 0, 0, 0, 0);
      capture(2, 1, 4, 1, 0, 0, 0);
      force_long = 1'b1;
      capture(0, 1, 2, 0, 0, 0, 0);
      force_long = 1'b0;
      capture(1, 0, 3, 2, 1, 1, 0);
      force_long = 1'b1;
      capture(0, 3, 2, 0, 0, 0, 2);
      force_long = 1'b0;
      capture(0, 0, 3, 0, 0, 0, 0);
      for (int n = 0; n < 6; n++) begin
         capture(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 6)), 2, int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 1)), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
